// File: rtl/divider_sweep_if.sv
// divider_sweep_if: control/status bundle between a sweep controller and divider_sweep.
//   start, abort, loop            sweep control (driven by master)
//   start_load, end_load, step    sweep range and increment (driven by master)
//   dwell                         divider toggles per load value (driven by master)
//   div_in                        divider output, already in the clk_in domain (driven by master)
//   load, busy, done              load word and status (driven by slave)
interface divider_sweep_if #(
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned DWELL_W = 16
);
  logic               start;
  logic               abort;
  logic               loop;
  logic [WIDTH-1:0]   start_load;
  logic [WIDTH-1:0]   end_load;
  logic [WIDTH-1:0]   step;
  logic [DWELL_W-1:0] dwell;
  logic               div_in;
  logic [WIDTH-1:0]   load;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, loop, start_load, end_load, step, dwell, div_in,
    input  load, busy, done
  );

  modport slave (
    input  start, abort, loop, start_load, end_load, step, dwell, div_in,
    output load, busy, done
  );
endinterface

// File: rtl/divider_sweep.sv
// divider_sweep: steps the divider load word linearly from start_load to end_load, holding
// each value for `dwell` toggles of the divider output fed back on div_in.
//   clk_in   system clock (same as the divider)
//   reset    asynchronous, active-high
//   bus      divider_sweep_if slave: start/abort/loop, range, step, dwell, div_in in;
//            load/busy/done out (all registered)
module divider_sweep #(
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned DWELL_W = 16
) (
  input logic            clk_in,
  input logic            reset,
  divider_sweep_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   load_q;
  logic               busy_q;
  logic               done_q;
  logic               div_prev_q;
  logic [DWELL_W-1:0] dwell_cnt_q;
  logic [WIDTH-1:0]   start_q;
  logic [WIDTH-1:0]   end_q;
  logic [WIDTH-1:0]   step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               loop_q;
  logic               dir_up_q;

  logic               toggle;
  logic [DWELL_W-1:0] dwell_eff;
  logic [DWELL_W:0]   cnt_inc;
  logic               dwell_more;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH-1:0]   next_load;

  assign toggle = bus.div_in ^ div_prev_q;

  // A dwell of 0 behaves like 1 so every value is held for at least one toggle.
  assign dwell_eff  = (dwell_q == '0) ? {{(DWELL_W-1){1'b0}}, 1'b1} : dwell_q;
  assign cnt_inc    = {1'b0, dwell_cnt_q} + {{DWELL_W{1'b0}}, 1'b1};
  assign dwell_more = cnt_inc < {1'b0, dwell_eff};

  // One extra bit so overflow (up) and underflow (down) saturate at end instead of wrapping.
  assign sum_w  = {1'b0, load_q} + {1'b0, step_q};
  assign diff_w = {1'b0, load_q} - {1'b0, step_q};

  always_comb begin
    next_load = end_q;
    if (dir_up_q) begin
      if (sum_w <= {1'b0, end_q}) next_load = sum_w[WIDTH-1:0];
    end else begin
      if (!diff_w[WIDTH] && (diff_w[WIDTH-1:0] >= end_q)) next_load = diff_w[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      load_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_prev_q  <= 1'b0;
      dwell_cnt_q <= '0;
      start_q     <= '0;
      end_q       <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      loop_q      <= 1'b0;
      dir_up_q    <= 1'b0;
    end else begin
      div_prev_q <= bus.div_in;
      done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            start_q     <= bus.start_load;
            end_q       <= bus.end_load;
            step_q      <= bus.step;
            dwell_q     <= bus.dwell;
            loop_q      <= bus.loop;
            dir_up_q    <= bus.end_load >= bus.start_load;
            load_q      <= bus.start_load;
            dwell_cnt_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= StRun;
          end
        end
        StRun: begin
          if (bus.abort) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (toggle) begin
            if (dwell_more) begin
              dwell_cnt_q <= cnt_inc[DWELL_W-1:0];
            end else begin
              dwell_cnt_q <= '0;
              if (load_q == end_q) begin
                if (loop_q) begin
                  load_q <= start_q;
                end else begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
                end
              end else begin
                load_q <= next_load;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.load = load_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_divider_sweep.sv
// Directed bench for divider_sweep with hand-computed expected load/busy/done values.
module tb_divider_sweep;

  logic clk_in;
  logic reset;
  int   n_checks;
  int   n_errors;

  divider_sweep_if #(.WIDTH(24), .DWELL_W(16)) bus ();

  divider_sweep #(.WIDTH(24), .DWELL_W(16)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock, then settle just after the edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One divider-output toggle seen at the next edge, then idle cycles to pace it.
  task automatic div_toggle(input int idle);
    bus.div_in = ~bus.div_in;
    tick();
    for (int i = 0; i < idle; i++) tick();
  endtask

  task automatic start_sweep(input logic [23:0] s, input logic [23:0] e, input logic [23:0] st,
                             input logic [15:0] dw, input logic lp);
    bus.start_load = s;
    bus.end_load   = e;
    bus.step       = st;
    bus.dwell      = dw;
    bus.loop       = lp;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.loop       = 1'b0;
    bus.start_load = '0;
    bus.end_load   = '0;
    bus.step       = '0;
    bus.dwell      = '0;
    bus.div_in     = 1'b0;
    #3;
    check_eq("rst_load", 32'(bus.load), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    #10 reset = 1'b0;
    tick();

    // Up sweep 4 -> 7 -> 10, dwell 2, toggles every 5 cycles.
    start_sweep(24'd4, 24'd10, 24'd3, 16'd2, 1'b0);
    check_eq("up_start_load", 32'(bus.load), 32'd4);
    check_eq("up_start_busy", 32'(bus.busy), 32'd1);
    div_toggle(4);
    check_eq("up_t1", 32'(bus.load), 32'd4);
    div_toggle(4);
    check_eq("up_t2", 32'(bus.load), 32'd7);
    div_toggle(4);
    check_eq("up_t3", 32'(bus.load), 32'd7);
    div_toggle(4);
    check_eq("up_t4", 32'(bus.load), 32'd10);
    div_toggle(4);
    check_eq("up_t5", 32'(bus.load), 32'd10);
    check_eq("up_t5_done", 32'(bus.done), 32'd0);
    div_toggle(0);
    check_eq("up_done", 32'(bus.done), 32'd1);
    check_eq("up_done_busy", 32'(bus.busy), 32'd0);
    check_eq("up_done_load", 32'(bus.load), 32'd10);
    tick();
    check_eq("up_done_clr", 32'(bus.done), 32'd0);

    // Down sweep with saturation at end: 20, 12, 4, 3.
    start_sweep(24'd20, 24'd3, 24'd8, 16'd1, 1'b0);
    check_eq("dn_0", 32'(bus.load), 32'd20);
    div_toggle(2);
    check_eq("dn_1", 32'(bus.load), 32'd12);
    div_toggle(2);
    check_eq("dn_2", 32'(bus.load), 32'd4);
    div_toggle(2);
    check_eq("dn_3", 32'(bus.load), 32'd3);
    check_eq("dn_3_busy", 32'(bus.busy), 32'd1);
    div_toggle(0);
    check_eq("dn_done", 32'(bus.done), 32'd1);
    tick();

    // No wrap at the top of the range.
    start_sweep(24'hFFFFF0, 24'hFFFFFF, 24'h20, 16'd1, 1'b0);
    check_eq("nw_0", 32'(bus.load), 32'h00FFFFF0);
    div_toggle(2);
    check_eq("nw_1", 32'(bus.load), 32'h00FFFFFF);
    div_toggle(0);
    check_eq("nw_done", 32'(bus.done), 32'd1);
    check_eq("nw_done_load", 32'(bus.load), 32'h00FFFFFF);
    tick();

    // Looping sweep, ignored start in RUN, then abort at load 2.
    start_sweep(24'd1, 24'd3, 24'd1, 16'd1, 1'b1);
    check_eq("lp_0", 32'(bus.load), 32'd1);
    div_toggle(2);
    check_eq("lp_1", 32'(bus.load), 32'd2);
    div_toggle(2);
    check_eq("lp_2", 32'(bus.load), 32'd3);
    div_toggle(2);
    check_eq("lp_wrap", 32'(bus.load), 32'd1);
    check_eq("lp_wrap_done", 32'(bus.done), 32'd0);
    div_toggle(2);
    check_eq("lp_4", 32'(bus.load), 32'd2);
    start_sweep(24'd9, 24'd9, 24'd1, 16'd1, 1'b0);
    check_eq("lp_start_ign", 32'(bus.load), 32'd2);
    check_eq("lp_start_busy", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("ab_busy", 32'(bus.busy), 32'd0);
    check_eq("ab_load", 32'(bus.load), 32'd2);
    check_eq("ab_done", 32'(bus.done), 32'd0);
    div_toggle(1);
    check_eq("ab_idle_load", 32'(bus.load), 32'd2);
    check_eq("ab_idle_done", 32'(bus.done), 32'd0);

    // dwell 0 with start == end: done on the first toggle.
    start_sweep(24'd5, 24'd5, 24'd1, 16'd0, 1'b0);
    check_eq("d0_load", 32'(bus.load), 32'd5);
    div_toggle(0);
    check_eq("d0_done", 32'(bus.done), 32'd1);
    check_eq("d0_busy", 32'(bus.busy), 32'd0);
    tick();

    // Asynchronous reset mid-sweep.
    start_sweep(24'd4, 24'd10, 24'd3, 16'd1, 1'b0);
    div_toggle(0);
    check_eq("ar_pre", 32'(bus.load), 32'd7);
    #2 reset = 1'b1;
    #1;
    check_eq("ar_load", 32'(bus.load), 32'd0);
    check_eq("ar_busy", 32'(bus.busy), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Fresh sweep after reset.
    start_sweep(24'd4, 24'd10, 24'd3, 16'd1, 1'b0);
    check_eq("fr_0", 32'(bus.load), 32'd4);
    check_eq("fr_busy", 32'(bus.busy), 32'd1);
    div_toggle(1);
    check_eq("fr_1", 32'(bus.load), 32'd7);
    div_toggle(1);
    check_eq("fr_2", 32'(bus.load), 32'd10);
    div_toggle(0);
    check_eq("fr_done", 32'(bus.done), 32'd1);
    tick();
    check_eq("fr_done_clr", 32'(bus.done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
